// File: rtl/uart_tx_param.sv
// UART transmitter with input FIFO, valid/ready write port, per-frame baud select,
// configurable data width, parity and stop bits; frames stream back-to-back.
module uart_tx_param #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [2:0]                  baud_set,
    input  logic [DATA_BITS-1:0]        tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        rs232_tx,
    output logic                        tx_busy,
    output logic                        tx_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(CLK_FREQ / 9600);
    localparam int BC_W  = 4;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    function automatic logic [CNT_W-1:0] div_m1(input logic [2:0] sel);
        case (sel)
            3'd1:    return CNT_W'(CLK_FREQ / 19200 - 1);
            3'd2:    return CNT_W'(CLK_FREQ / 38400 - 1);
            3'd3:    return CNT_W'(CLK_FREQ / 57600 - 1);
            3'd4:    return CNT_W'(CLK_FREQ / 115200 - 1);
            default: return CNT_W'(CLK_FREQ / 9600 - 1);
        endcase
    endfunction

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr, rd_ptr;
    logic [DATA_BITS-1:0] rd_data;
    logic                 push, pop, empty;

    assign fifo_level = wr_ptr - rd_ptr;
    assign empty      = (fifo_level == '0);
    assign tx_ready   = (fifo_level != (AW+1)'(FIFO_DEPTH));
    // Full refuses the write even if a pop happens in the same cycle.
    assign push       = tx_valid && tx_ready;
    assign rd_data    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= tx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    state_t               state;
    logic [CNT_W-1:0]     baud_cnt, div_reg;
    logic [BC_W-1:0]      bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit, bit_end, last_data, last_stop, frame_end, line_bit;

    assign bit_end   = (baud_cnt == div_reg);
    assign last_data = (bit_cnt == BC_W'(DATA_BITS - 1));
    assign last_stop = (bit_cnt == BC_W'(STOP_BITS - 1));
    assign frame_end = (state == S_STOP) && bit_end && last_stop;
    // Popping on the final stop cycle lets the next start bit follow with no gap.
    assign pop       = !empty && ((state == S_IDLE) || frame_end);

    always_comb begin
        line_bit = 1'b1;
        case (state)
            S_START:  line_bit = 1'b0;
            S_DATA:   line_bit = shreg[0];
            S_PARITY: line_bit = par_bit;
            default:  line_bit = 1'b1;
        endcase
    end

    // Line, busy and done are registered from the state, so they trail it by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            div_reg  <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            rs232_tx <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            rs232_tx <= line_bit;
            tx_busy  <= (state != S_IDLE);
            tx_done  <= frame_end;
            if (state != S_IDLE)
                baud_cnt <= bit_end ? '0 : baud_cnt + CNT_W'(1);
            case (state)
                S_IDLE: ;
                S_START: if (bit_end) state <= S_DATA;
                S_DATA: if (bit_end) begin
                    shreg <= shreg >> 1;
                    if (last_data) begin
                        bit_cnt <= '0;
                        state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt <= bit_cnt + BC_W'(1);
                    end
                end
                S_PARITY: if (bit_end) state <= S_STOP;
                S_STOP: if (bit_end) begin
                    if (last_stop) begin
                        bit_cnt <= '0;
                        state   <= S_IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + BC_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (pop) begin
                state    <= S_START;
                shreg    <= rd_data;
                par_bit  <= (PARITY == 1) ? ~^rd_data : ^rd_data;
                div_reg  <= div_m1(baud_set);
                baud_cnt <= '0;
                bit_cnt  <= '0;
            end
        end
    end
endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter with an input FIFO, valid/ready write handshake, selectable baud rate, configurable data width, parity and stop bits. It replaces the single-byte, button-triggered transmitter: upstream logic streams bytes without waiting for `tx_done`, and frames go out back-to-back while the FIFO holds data. It sits between any byte producer (command engine, debug logger, key-driven test logic) and the `rs232_tx` pin.

## Interface

- `CLK_FREQ`, 50_000_000: clock frequency in Hz.
- `DATA_BITS`, 8: data bits per frame; legal range 5..9.
- `PARITY`, 0: parity mode; 0 none, 1 odd, 2 even.
- `STOP_BITS`, 1: stop bits per frame; legal values 1 or 2.
- `FIFO_DEPTH`, 16: FIFO entries; power of two, at least 2.

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `baud_set`  in  3  baud rate select: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200. Values 5..7 select 9600.
- `tx_data`  in  DATA_BITS  byte to enqueue.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  FIFO can accept a word; equals not-full.
- `rs232_tx`  out  1  serial line; idles high.
- `tx_busy`  out  1  high while a frame is on the line (start bit through last stop bit).
- `tx_done`  out  1  one-cycle pulse on the last cycle of each frame's final stop bit.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  number of words held in the FIFO.

## Operation

- Write: a word is accepted on a rising edge where `tx_valid && tx_ready`. Words are transmitted in order.
- Full FIFO: `tx_ready` is low. A write in the same cycle as a pop is still refused; there is no write-through on full.
- Baud divisor: DIV = CLK_FREQ / baud, integer division. Each line bit lasts exactly DIV cycles.
  - `baud_set` is sampled once, at the pop that starts a frame, and held for the whole frame.
  - Changing `baud_set` mid-frame has no effect until the next frame.
- Frame format: start bit (0), then DATA_BITS data bits LSB first, then the parity bit if PARITY≠0, then STOP_BITS stop bits (1).
  - Odd parity: the parity bit is chosen so that data bits plus parity contain an odd number of ones.
  - Even parity: data bits plus parity contain an even number of ones.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START: on FIFO non-empty. The word is popped and latched in a shift register.
  - START → DATA: after DIV cycles.
  - DATA → PARITY: after DATA_BITS × DIV cycles, if PARITY≠0.
  - DATA → STOP: after DATA_BITS × DIV cycles, if PARITY=0.
  - PARITY → STOP: after DIV cycles.
  - STOP → START: after STOP_BITS × DIV cycles, if the FIFO is non-empty. The pop happens on the final stop cycle, so there is no idle gap between frames.
  - STOP → IDLE: after STOP_BITS × DIV cycles, if the FIFO is empty.
- Counters: a baud counter of width $clog2(CLK_FREQ/9600) counts 0..DIV-1. A bit counter tracks position within the DATA and STOP states.
- `rs232_tx` is driven from a register and never glitches.

## Timing

- Reset values:
  - `rs232_tx`=1, `tx_busy`=0, `tx_done`=0, `tx_ready`=1, `fifo_level`=0.
  - FSM in IDLE, counters 0.
  - FIFO pointers cleared.
- Reset asserted mid-frame: the line returns high asynchronously and all queued data is discarded.
- Latency into an idle, empty block:
  - Write accepted at edge k.
  - Pop at edge k+1.
  - `rs232_tx` goes low after edge k+2.
- Frame length: (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × DIV cycles.
- `tx_busy` rises with the start bit and falls after the final stop cycle. It stays high continuously across back-to-back frames.
- `tx_done` is high during the final stop-bit cycle of each frame, including frames followed immediately by another frame.
- `fifo_level` updates on the edge after a push or pop. A simultaneous push and pop leaves it unchanged.

## Test plan

Use CLK_FREQ=1_152_000 for the bench, giving DIV=10 at `baud_set`=4 and DIV=120 at `baud_set`=0.

- Reset mid-frame: assert `rst_n`=0 during a data bit → `rs232_tx`=1 immediately; after release, `fifo_level`=0 and `tx_ready`=1.
- Single byte, 8N1, `baud_set`=4: write 0xA5 → line low 2 cycles after the write. Bits 1,0,1,0,0,1,0,1 follow, 10 cycles each, then a 10-cycle stop bit. `tx_done` pulses at cycle 100 of the frame.
- Back-to-back: write 0x00, 0xFF, 0x55 in consecutive cycles → three 100-cycle frames with no high gap between the stop bit and the next start bit. `tx_busy` stays high for 300 cycles and `tx_done` pulses three times.
- Full FIFO, FIFO_DEPTH=4: hold `tx_valid` high with values 1..8 → `tx_ready` drops once 4 words are queued. Only accepted words appear on the line, in order, with none duplicated or lost.
- Parity and stop bits, DATA_BITS=7, PARITY=1, STOP_BITS=2: send 0x03 → parity bit 1; frame is 11 bits, 110 cycles. Repeat with PARITY=2 → parity bit 0.
- Baud change: switch `baud_set` from 4 to 0 mid-frame → current frame completes at DIV=10 and the next frame runs at DIV=120.
